atm_session_ctrl: RTL and testbench
===================================

// Module: atm_session_ctrl
// PURPOSE
//  Parametrised ATM session controller: owns NUM_ACCOUNTS account records (PIN, balance, fail count),
//  runs login/menu sessions driven by a valid/ready command port and returns one response per command.
//  Adds over the fixed-width single-channel ATM FSM: PIN-retry lockout, deposit, PIN change, idle timeout, status codes.
//  Sits between the card/keypad front end and the display/dispenser back end.
// PARAMETERS
//  NUM_ACCOUNTS   4     number of account records (ID_W = $clog2(NUM_ACCOUNTS), min 1)
//  BAL_W          11    balance/amount width; MAX_BAL = 2**BAL_W-1
//  PIN_W          4     PIN width
//  INIT_BALANCE   500   balance of every account after reset
//  DEFAULT_PIN    4'h6  PIN of every account after reset
//  MAX_TRIES      3     consecutive wrong PINs that lock an account (1..7)
//  TIMEOUT_CYCLES 1000  idle cycles in MENU before forced logout (>=2)
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      controller accepts command this cycle
//  cmd_op         in   3      LOGIN0 BALANCE1 WITHDRAW2 DEPOSIT3 TRANSFER4 CHPIN5 LOGOUT6 (7 reserved)
//  cmd_acc        in   ID_W   account for LOGIN
//  cmd_pin        in   PIN_W  PIN for LOGIN; new PIN for CHPIN
//  cmd_dst        in   ID_W   destination for TRANSFER
//  cmd_amount     in   BAL_W  amount for WITHDRAW/DEPOSIT/TRANSFER
//  rsp_valid      out  1      one-cycle response pulse
//  rsp_status     out  3      OK0 BAD_PIN1 LOCKED2 INSUFF3 OVERFLOW4 BAD_ACC5 SEQ_ERR6 TIMEOUT7
//  rsp_balance    out  BAL_W  session account balance after command (0 if no session)
//  session_active out  1      a user is logged in
// BEHAVIOUR
//  Reset (async, any state, incl. mid-command): state IDLE; all outputs 0; balances=INIT_BALANCE,
//   PINs=DEFAULT_PIN, fail counts/locks cleared; in-flight command dropped, no response emitted.
//  FSM: IDLE -> EXEC -> RESP -> (MENU|IDLE); MENU -> EXEC -> RESP -> (MENU|IDLE); MENU -timeout-> RESP -> IDLE.
//  cmd_ready=1 only in IDLE and MENU; command latched on cmd_valid&&cmd_ready (cycle N);
//   EXEC at N+1 updates records; rsp_valid=1 at N+2 for exactly one cycle; cmd_ready again at N+3.
//  IDLE: only LOGIN legal, else SEQ_ERR. MENU: LOGIN or reserved op -> SEQ_ERR, session kept.
//  LOGIN: cmd_acc>=NUM_ACCOUNTS -> BAD_ACC; locked -> LOCKED (even with right PIN);
//   wrong PIN -> fail_cnt+1, BAD_PIN, or LOCKED if fail_cnt reaches MAX_TRIES (lock until reset);
//   right PIN -> fail_cnt=0, OK, session_active=1 from RESP cycle.
//  WITHDRAW: amount>balance -> INSUFF, no change; else balance-=amount (amount 0 -> OK, unchanged).
//  DEPOSIT: balance+amount computed at BAL_W+1 bits; >MAX_BAL -> OVERFLOW, no change.
//  TRANSFER: dst>=NUM_ACCOUNTS or dst==own -> BAD_ACC; amount>balance -> INSUFF;
//   dst balance+amount>MAX_BAL -> OVERFLOW; any error leaves both balances unchanged; else atomic in EXEC.
//  CHPIN: PIN:=cmd_pin, OK. BALANCE: OK, no change. LOGOUT: OK, rsp_balance=final, then IDLE.
//  Error check priority: SEQ_ERR > BAD_ACC > LOCKED > BAD_PIN > INSUFF > OVERFLOW.
//  Timeout: idle counter runs in MENU, cleared on each accepted command; at TIMEOUT_CYCLES
//   cmd_ready drops that cycle (timeout beats a simultaneous cmd_valid), next cycle unsolicited
//   rsp_valid with TIMEOUT, session_active=0, -> IDLE.
//  rsp_status/rsp_balance held stable and meaningful only while rsp_valid=1; 0 otherwise.
// STRUCTURE
//  Package atm_pkg: op codes, status codes, FSM state enum, ID_W helper function.
//  Sub-module atm_account_bank: NUM_ACCOUNTS x {PIN, balance, fail_cnt, locked}, two read ports
//   (session, dst), two write ports (same-cycle transfer), async reset init. FSM/arith in top.
// TESTING (NUM_ACCOUNTS=4, BAL_W=11, INIT_BALANCE=500, DEFAULT_PIN=6, MAX_TRIES=3, TIMEOUT_CYCLES=20)
//  LOGIN acc1 pin6 -> rsp at N+2: OK bal500, session_active=1; BALANCE -> OK 500.
//  WITHDRAW 100 -> OK 400; WITHDRAW 2000 -> INSUFF 400; DEPOSIT 1700 -> OVERFLOW 400.
//  TRANSFER 50 to acc2 -> OK 400-50=350; LOGOUT; LOGIN acc2 pin6 -> OK bal550; TRANSFER to acc2 -> BAD_ACC.
//  LOGIN acc3 pin5 x2 -> BAD_PIN,BAD_PIN; 3rd -> LOCKED; pin6 -> LOCKED; reset -> pin6 login OK 500.
//  In MENU idle 20 cycles with cmd_valid asserted on expiry cycle -> not accepted, TIMEOUT rsp, session 0.
//  rst_n low during EXEC of WITHDRAW 100 -> no rsp_valid, balance back to 500; BALANCE in IDLE -> SEQ_ERR.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: command opcodes, response
// status codes, FSM states and the account-index width helper.
package atm_pkg;

    localparam int FAIL_W = 3;

    typedef enum logic [2:0] {
        OP_LOGIN    = 3'd0,
        OP_BALANCE  = 3'd1,
        OP_WITHDRAW = 3'd2,
        OP_DEPOSIT  = 3'd3,
        OP_TRANSFER = 3'd4,
        OP_CHPIN    = 3'd5,
        OP_LOGOUT   = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_OK       = 3'd0,
        ST_BAD_PIN  = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_INSUFF   = 3'd3,
        ST_OVERFLOW = 3'd4,
        ST_BAD_ACC  = 3'd5,
        ST_SEQ_ERR  = 3'd6,
        ST_TIMEOUT  = 3'd7
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MENU = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Command/response port between the keypad front end (master) and the
// session controller (slave).
interface atm_cmd_if #(
    parameter int ID_W  = 2,
    parameter int PIN_W = 4,
    parameter int BAL_W = 11
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [ID_W-1:0]  cmd_acc;
    logic [PIN_W-1:0] cmd_pin;
    logic [ID_W-1:0]  cmd_dst;
    logic [BAL_W-1:0] cmd_amount;
    logic             rsp_valid;
    logic [2:0]       rsp_status;
    logic [BAL_W-1:0] rsp_balance;

    modport master (
        output cmd_valid, cmd_op, cmd_acc, cmd_pin, cmd_dst, cmd_amount,
        input  cmd_ready, rsp_valid, rsp_status, rsp_balance
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_acc, cmd_pin, cmd_dst, cmd_amount,
        output cmd_ready, rsp_valid, rsp_status, rsp_balance
    );
endinterface

// File: rtl/atm_account_bank.sv
// Account record storage: PIN, balance, fail count and lock flag per account.
// Port A is the session account (full record), port B the transfer destination.
module atm_account_bank
    import atm_pkg::*;
#(
    parameter int               NUM_ACCOUNTS = 4,
    parameter int               BAL_W        = 11,
    parameter int               PIN_W        = 4,
    parameter int               INIT_BALANCE = 500,
    parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'h6,
    parameter int               ID_W         = id_w(NUM_ACCOUNTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   a_id,
    output logic [PIN_W-1:0]  a_pin,
    output logic [BAL_W-1:0]  a_bal,
    output logic [FAIL_W-1:0] a_fail,
    output logic              a_locked,
    input  logic              wr_a_en,
    input  logic [PIN_W-1:0]  wr_a_pin,
    input  logic [BAL_W-1:0]  wr_a_bal,
    input  logic [FAIL_W-1:0] wr_a_fail,
    input  logic              wr_a_locked,
    input  logic [ID_W-1:0]   b_id,
    output logic [BAL_W-1:0]  b_bal,
    input  logic              wr_b_en,
    input  logic [BAL_W-1:0]  wr_b_bal
);
    logic [PIN_W-1:0]  pin_q    [NUM_ACCOUNTS];
    logic [PIN_W-1:0]  pin_d    [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  bal_q    [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  bal_d    [NUM_ACCOUNTS];
    logic [FAIL_W-1:0] fail_q   [NUM_ACCOUNTS];
    logic [FAIL_W-1:0] fail_d   [NUM_ACCOUNTS];
    logic              locked_q [NUM_ACCOUNTS];
    logic              locked_d [NUM_ACCOUNTS];

    // Decoded reads: an index past NUM_ACCOUNTS reads as an all-zero record.
    always_comb begin
        a_pin    = '0;
        a_bal    = '0;
        a_fail   = '0;
        a_locked = 1'b0;
        b_bal    = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (a_id == ID_W'(i)) begin
                a_pin    = pin_q[i];
                a_bal    = bal_q[i];
                a_fail   = fail_q[i];
                a_locked = locked_q[i];
            end
            if (b_id == ID_W'(i)) begin
                b_bal = bal_q[i];
            end
        end
    end

    always_comb begin
        pin_d    = pin_q;
        bal_d    = bal_q;
        fail_d   = fail_q;
        locked_d = locked_q;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (wr_a_en && a_id == ID_W'(i)) begin
                pin_d[i]    = wr_a_pin;
                bal_d[i]    = wr_a_bal;
                fail_d[i]   = wr_a_fail;
                locked_d[i] = wr_a_locked;
            end
            if (wr_b_en && b_id == ID_W'(i)) begin
                bal_d[i] = wr_b_bal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                pin_q[i]    <= DEFAULT_PIN;
                bal_q[i]    <= BAL_W'(INIT_BALANCE);
                fail_q[i]   <= '0;
                locked_q[i] <= 1'b0;
            end
        end else begin
            pin_q    <= pin_d;
            bal_q    <= bal_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: login/menu sequencing, account arithmetic, PIN
// lockout and idle timeout, one response per accepted command.
//   state | meaning
//   IDLE  | no session, accepting LOGIN
//   MENU  | session open, accepting commands, idle timer counting down
//   EXEC  | latched command evaluated, account records updated
//   RESP  | rsp_valid pulse with registered status/balance
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int               NUM_ACCOUNTS   = 4,
    parameter int               BAL_W          = 11,
    parameter int               PIN_W          = 4,
    parameter int               INIT_BALANCE   = 500,
    parameter logic [PIN_W-1:0] DEFAULT_PIN    = 4'h6,
    parameter int               MAX_TRIES      = 3,
    parameter int               TIMEOUT_CYCLES = 1000
) (
    input  logic      clk,
    input  logic      rst_n,
    atm_cmd_if.slave  bus,
    output logic      session_active
);
    localparam int ID_W  = id_w(NUM_ACCOUNTS);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    function automatic logic acc_ok(input logic [ID_W-1:0] id);
        return 32'(id) < NUM_ACCOUNTS;
    endfunction

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    status_e            status_q, status_d;
    logic [ID_W-1:0]    acc_q, acc_d, dst_q, dst_d, sess_id_q, sess_id_d;
    logic [PIN_W-1:0]   pin_q, pin_d;
    logic [BAL_W-1:0]   amt_q, amt_d, rsp_bal_q, rsp_bal_d;
    logic               session_q, session_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               ready;

    logic [ID_W-1:0]    rd_id;
    logic [PIN_W-1:0]   a_pin, wr_a_pin;
    logic [BAL_W-1:0]   a_bal, b_bal, wr_a_bal, wr_b_bal, wd_bal;
    logic [FAIL_W-1:0]  a_fail, wr_a_fail, fail_inc;
    logic               a_locked, wr_a_locked, wr_a_en, wr_b_en, insuff;
    logic [BAL_W:0]     dep_sum, dst_sum;

    assign rd_id    = session_q ? sess_id_q : acc_q;
    assign dep_sum  = {1'b0, a_bal} + {1'b0, amt_q};
    assign dst_sum  = {1'b0, b_bal} + {1'b0, amt_q};
    assign wd_bal   = a_bal - amt_q;
    assign insuff   = amt_q > a_bal;
    assign fail_inc = a_fail + FAIL_W'(1);

    atm_account_bank #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .BAL_W        (BAL_W),
        .PIN_W        (PIN_W),
        .INIT_BALANCE (INIT_BALANCE),
        .DEFAULT_PIN  (DEFAULT_PIN),
        .ID_W         (ID_W)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_id        (rd_id),
        .a_pin       (a_pin),
        .a_bal       (a_bal),
        .a_fail      (a_fail),
        .a_locked    (a_locked),
        .wr_a_en     (wr_a_en),
        .wr_a_pin    (wr_a_pin),
        .wr_a_bal    (wr_a_bal),
        .wr_a_fail   (wr_a_fail),
        .wr_a_locked (wr_a_locked),
        .b_id        (dst_q),
        .b_bal       (b_bal),
        .wr_b_en     (wr_b_en),
        .wr_b_bal    (wr_b_bal)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        dst_d       = dst_q;
        pin_d       = pin_q;
        amt_d       = amt_q;
        sess_id_d   = sess_id_q;
        session_d   = session_q;
        status_d    = status_q;
        rsp_bal_d   = rsp_bal_q;
        tmr_d       = tmr_q;
        ready       = 1'b0;
        wr_a_en     = 1'b0;
        wr_a_pin    = a_pin;
        wr_a_bal    = a_bal;
        wr_a_fail   = a_fail;
        wr_a_locked = a_locked;
        wr_b_en     = 1'b0;
        wr_b_bal    = dst_sum[BAL_W-1:0];

        unique case (state_q)
            S_IDLE: ready = 1'b1;
            S_MENU: begin
                // Expiry wins over a command presented in the same cycle.
                if (tmr_q == '0) begin
                    state_d   = S_RESP;
                    status_d  = ST_TIMEOUT;
                    rsp_bal_d = '0;
                    session_d = 1'b0;
                end else begin
                    ready = 1'b1;
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_EXEC: begin
                state_d   = S_RESP;
                rsp_bal_d = '0;
                if (!session_q) begin
                    if (op_q != OP_LOGIN) begin
                        status_d = ST_SEQ_ERR;
                    end else if (!acc_ok(acc_q)) begin
                        status_d = ST_BAD_ACC;
                    end else if (a_locked) begin
                        status_d = ST_LOCKED;
                    end else if (pin_q != a_pin) begin
                        wr_a_en   = 1'b1;
                        wr_a_fail = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_TRIES)) begin
                            wr_a_locked = 1'b1;
                            status_d    = ST_LOCKED;
                        end else begin
                            status_d = ST_BAD_PIN;
                        end
                    end else begin
                        wr_a_en   = 1'b1;
                        wr_a_fail = '0;
                        status_d  = ST_OK;
                        session_d = 1'b1;
                        sess_id_d = acc_q;
                        rsp_bal_d = a_bal;
                    end
                end else begin
                    status_d  = ST_OK;
                    rsp_bal_d = a_bal;
                    case (op_q)
                        OP_BALANCE: ;
                        OP_WITHDRAW: begin
                            if (insuff) begin
                                status_d = ST_INSUFF;
                            end else begin
                                wr_a_en   = 1'b1;
                                wr_a_bal  = wd_bal;
                                rsp_bal_d = wd_bal;
                            end
                        end
                        OP_DEPOSIT: begin
                            if (dep_sum[BAL_W]) begin
                                status_d = ST_OVERFLOW;
                            end else begin
                                wr_a_en   = 1'b1;
                                wr_a_bal  = dep_sum[BAL_W-1:0];
                                rsp_bal_d = dep_sum[BAL_W-1:0];
                            end
                        end
                        OP_TRANSFER: begin
                            if (!acc_ok(dst_q) || dst_q == sess_id_q) begin
                                status_d = ST_BAD_ACC;
                            end else if (insuff) begin
                                status_d = ST_INSUFF;
                            end else if (dst_sum[BAL_W]) begin
                                status_d = ST_OVERFLOW;
                            end else begin
                                wr_a_en   = 1'b1;
                                wr_a_bal  = wd_bal;
                                wr_b_en   = 1'b1;
                                rsp_bal_d = wd_bal;
                            end
                        end
                        OP_CHPIN: begin
                            wr_a_en  = 1'b1;
                            wr_a_pin = pin_q;
                        end
                        OP_LOGOUT: session_d = 1'b0;
                        default: status_d = ST_SEQ_ERR;
                    endcase
                end
            end
            S_RESP: begin
                state_d = session_q ? S_MENU : S_IDLE;
                tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
            end
            default: state_d = S_IDLE;
        endcase

        if (ready && bus.cmd_valid) begin
            state_d = S_EXEC;
            op_d    = op_e'(bus.cmd_op);
            acc_d   = bus.cmd_acc;
            dst_d   = bus.cmd_dst;
            pin_d   = bus.cmd_pin;
            amt_d   = bus.cmd_amount;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOGIN;
            status_q  <= ST_OK;
            acc_q     <= '0;
            dst_q     <= '0;
            sess_id_q <= '0;
            pin_q     <= '0;
            amt_q     <= '0;
            rsp_bal_q <= '0;
            session_q <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            status_q  <= status_d;
            acc_q     <= acc_d;
            dst_q     <= dst_d;
            sess_id_q <= sess_id_d;
            pin_q     <= pin_d;
            amt_q     <= amt_d;
            rsp_bal_q <= rsp_bal_d;
            session_q <= session_d;
            tmr_q     <= tmr_d;
        end
    end

    assign bus.cmd_ready   = ready;
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_status  = (state_q == S_RESP) ? status_q : 3'd0;
    assign bus.rsp_balance = (state_q == S_RESP) ? rsp_bal_q : '0;
    assign session_active  = session_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: login/menu arithmetic, lockout,
// idle timeout and reset behaviour with hand-computed expectations.
module tb_atm_session_ctrl;
    import atm_pkg::*;

    localparam int NA = 4;
    localparam int BW = 11;
    localparam int PW = 4;
    localparam int IW = 2;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic session_active;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    atm_cmd_if #(.ID_W(IW), .PIN_W(PW), .BAL_W(BW)) bus ();

    atm_session_ctrl #(
        .NUM_ACCOUNTS   (NA),
        .BAL_W          (BW),
        .PIN_W          (PW),
        .INIT_BALANCE   (500),
        .DEFAULT_PIN    (4'h6),
        .MAX_TRIES      (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .session_active (session_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue one command (called at a negedge) and check its response.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [IW-1:0] acc,
                          input logic [PW-1:0] pin, input logic [IW-1:0] dst, input logic [BW-1:0] amt,
                          input logic [2:0] exp_st, input logic [BW-1:0] exp_bal, input logic exp_sa);
        int n;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_acc    = acc;
        bus.cmd_pin    = pin;
        bus.cmd_dst    = dst;
        bus.cmd_amount = amt;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) break;
        end
        check({tag, "/lat"}, n, 2);
        check({tag, "/st"}, bus.rsp_status, exp_st);
        check({tag, "/bal"}, bus.rsp_balance, exp_bal);
        check({tag, "/sa"}, session_active, exp_sa);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_acc    = '0;
        bus.cmd_pin    = '0;
        bus.cmd_dst    = '0;
        bus.cmd_amount = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("rst/rsp_valid", bus.rsp_valid, 0);
        check("rst/rsp_status", bus.rsp_status, 0);
        check("rst/rsp_balance", bus.rsp_balance, 0);
        check("rst/session", session_active, 0);
        check("rst/ready", bus.cmd_ready, 1);

        do_cmd("login1",     OP_LOGIN,    2'd1, 4'h6, 2'd0, 11'd0,    ST_OK,       11'd500,  1'b1);
        do_cmd("balance",    OP_BALANCE,  2'd0, 4'h0, 2'd0, 11'd0,    ST_OK,       11'd500,  1'b1);
        do_cmd("wd100",      OP_WITHDRAW, 2'd0, 4'h0, 2'd0, 11'd100,  ST_OK,       11'd400,  1'b1);
        do_cmd("wd2000",     OP_WITHDRAW, 2'd0, 4'h0, 2'd0, 11'd2000, ST_INSUFF,   11'd400,  1'b1);
        do_cmd("dep1700",    OP_DEPOSIT,  2'd0, 4'h0, 2'd0, 11'd1700, ST_OVERFLOW, 11'd400,  1'b1);
        do_cmd("xfer50",     OP_TRANSFER, 2'd0, 4'h0, 2'd2, 11'd50,   ST_OK,       11'd350,  1'b1);
        do_cmd("logout1",    OP_LOGOUT,   2'd0, 4'h0, 2'd0, 11'd0,    ST_OK,       11'd350,  1'b0);
        do_cmd("login2",     OP_LOGIN,    2'd2, 4'h6, 2'd0, 11'd0,    ST_OK,       11'd550,  1'b1);
        do_cmd("xfer_self",  OP_TRANSFER, 2'd0, 4'h0, 2'd2, 11'd10,   ST_BAD_ACC,  11'd550,  1'b1);
        do_cmd("xfer_insuf", OP_TRANSFER, 2'd0, 4'h0, 2'd0, 11'd600,  ST_INSUFF,   11'd550,  1'b1);
        do_cmd("dep_to_max", OP_DEPOSIT,  2'd0, 4'h0, 2'd0, 11'd1497, ST_OK,       11'd2047, 1'b1);
        do_cmd("xfer500",    OP_TRANSFER, 2'd0, 4'h0, 2'd0, 11'd500,  ST_OK,       11'd1547, 1'b1);
        do_cmd("wd_all",     OP_WITHDRAW, 2'd0, 4'h0, 2'd0, 11'd1547, ST_OK,       11'd0,    1'b1);
        do_cmd("wd_zero",    OP_WITHDRAW, 2'd0, 4'h0, 2'd0, 11'd0,    ST_OK,       11'd0,    1'b1);
        do_cmd("chpin9",     OP_CHPIN,    2'd0, 4'h9, 2'd0, 11'd0,    ST_OK,       11'd0,    1'b1);
        do_cmd("menu_login", OP_LOGIN,    2'd1, 4'h6, 2'd0, 11'd0,    ST_SEQ_ERR,  11'd0,    1'b1);
        do_cmd("menu_rsvd",  OP_RSVD,     2'd0, 4'h0, 2'd0, 11'd0,    ST_SEQ_ERR,  11'd0,    1'b1);
        do_cmd("logout2",    OP_LOGOUT,   2'd0, 4'h0, 2'd0, 11'd0,    ST_OK,       11'd0,    1'b0);
        do_cmd("old_pin",    OP_LOGIN,    2'd2, 4'h6, 2'd0, 11'd0,    ST_BAD_PIN,  11'd0,    1'b0);
        do_cmd("new_pin",    OP_LOGIN,    2'd2, 4'h9, 2'd0, 11'd0,    ST_OK,       11'd0,    1'b1);
        do_cmd("logout3",    OP_LOGOUT,   2'd0, 4'h0, 2'd0, 11'd0,    ST_OK,       11'd0,    1'b0);
        do_cmd("login0",     OP_LOGIN,    2'd0, 4'h6, 2'd0, 11'd0,    ST_OK,       11'd1000, 1'b1);
        do_cmd("logout0",    OP_LOGOUT,   2'd0, 4'h0, 2'd0, 11'd0,    ST_OK,       11'd1000, 1'b0);

        do_cmd("pin_try1",   OP_LOGIN,    2'd3, 4'h5, 2'd0, 11'd0,    ST_BAD_PIN,  11'd0,    1'b0);
        do_cmd("pin_try2",   OP_LOGIN,    2'd3, 4'h5, 2'd0, 11'd0,    ST_BAD_PIN,  11'd0,    1'b0);
        do_cmd("pin_try3",   OP_LOGIN,    2'd3, 4'h5, 2'd0, 11'd0,    ST_LOCKED,   11'd0,    1'b0);
        do_cmd("locked_ok",  OP_LOGIN,    2'd3, 4'h6, 2'd0, 11'd0,    ST_LOCKED,   11'd0,    1'b0);

        do_reset();
        do_cmd("unlock3",    OP_LOGIN,    2'd3, 4'h6, 2'd0, 11'd0,    ST_OK,       11'd500,  1'b1);

        // Idle timeout: MENU cycles 1..19 ready, cycle 20 expires.
        @(posedge clk);
        repeat (TO - 2) @(posedge clk);
        @(negedge clk);
        check("to/ready_c19", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_BALANCE;
        @(negedge clk);
        check("to/ready_c20", bus.cmd_ready, 0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("to/rsp_valid", bus.rsp_valid, 1);
        check("to/status", bus.rsp_status, ST_TIMEOUT);
        check("to/session", session_active, 0);
        @(negedge clk);
        check("to/idle_rsp", bus.rsp_valid, 0);
        check("to/idle_ready", bus.cmd_ready, 1);

        do_cmd("login1_rst", OP_LOGIN,    2'd1, 4'h6, 2'd0, 11'd0,    ST_OK,       11'd500,  1'b1);

        // Reset lands in the EXEC cycle of a withdraw.
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = OP_WITHDRAW;
        bus.cmd_amount = 11'd100;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        check("mid/ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid/no_rsp", bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        check("mid/session", session_active, 0);

        do_cmd("idle_bal",   OP_BALANCE,  2'd0, 4'h0, 2'd0, 11'd0,    ST_SEQ_ERR,  11'd0,    1'b0);
        do_cmd("login1_chk", OP_LOGIN,    2'd1, 4'h6, 2'd0, 11'd0,    ST_OK,       11'd500,  1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
